int_ctrl: RTL and testbench

Memory-mapped programmable interrupt controller, placed downstream of the timers and the external interrupt pin and upstream of the CPU HWInt[7:2] inputs.
- Latches raw device interrupt lines into per-line pending bits (edge or level mode) and gates them with a mask.
- Presents the result to the CPU as hwint and int_req.
- Exposes MASK/MODE/PEND/VEC registers to the Bridge at word window 0x7F30-0x7F3F.

---
 rtl/int_ctrl_pkg.sv | 9 +
 rtl/int_line.sv | 33 +++
 rtl/int_ctrl.sv | 49 ++++
 tb/tb_int_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets, window base and default line count for int_ctrl
package int_ctrl_pkg;
  localparam int N_DEF = 6;
  localparam logic [1:0] OFF_MASK = 2'd0;
  localparam logic [1:0] OFF_MODE = 2'd1;
  localparam logic [1:0] OFF_PEND = 2'd2;
  localparam logic [1:0] OFF_VEC  = 2'd3;
  localparam logic [31:0] WIN_BASE = 32'h0000_7F30;
endpackage

// File: rtl/int_line.sv
// int_line: one interrupt line with optional synchronizer, rise detect and pending bit
module int_line #(
  parameter bit SYNC = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic level,
  input  logic clr,
  output logic pend
);
  logic s_in, src_q, src_d;
  if (SYNC) begin : g_sync
    logic meta;
    always_ff @(posedge clk or negedge reset)
      if (!reset) meta <= 1'b0;
      else meta <= src;
    assign s_in = meta;
  end else begin : g_direct
    assign s_in = src;
  end
  // level comes from the post-write MODE so an edge->level switch loads src_q at once
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      src_q <= 1'b0;
      src_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      src_q <= s_in;
      src_d <= src_q;
      pend  <= level ? src_q : (pend & ~clr) | (src_q & ~src_d);
    end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller with MASK/MODE/PEND/VEC registers
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int           N        = N_DEF,
  parameter logic [N-1:0] MASK_RST = 'b000111,
  parameter logic [N-1:0] SYNC_EN  = 'b000100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   addr,
  input  logic         we,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  input  logic [N-1:0] src,
  output logic [N-1:0] hwint,
  output logic         int_req
);
  logic [N-1:0] mask, mode, mode_nxt, pend, clr;
  logic [2:0] vec;
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:N];
  assign mode_nxt = (we && addr == OFF_MODE) ? wdata[N-1:0] : mode;
  assign clr = (we && addr == OFF_PEND) ? wdata[N-1:0] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mask <= MASK_RST;
      mode <= '0;
    end else begin
      if (we && addr == OFF_MASK) mask <= wdata[N-1:0];
      mode <= mode_nxt;
    end
  for (genvar i = 0; i < N; i++) begin : g_line
    int_line #(.SYNC(SYNC_EN[i])) u_line (
      .clk(clk), .reset(reset), .src(src[i]), .level(mode_nxt[i]), .clr(clr[i]), .pend(pend[i])
    );
  end
  assign hwint = pend & mask;
  assign int_req = |hwint;
  // scan downward so the lowest set index wins
  always_comb begin
    vec = '0;
    for (int i = N - 1; i >= 0; i--) if (hwint[i]) vec = 3'(i);
  end
  always_comb
    rdata = addr == OFF_MASK ? 32'(mask) :
            addr == OFF_MODE ? 32'(mode) :
            addr == OFF_PEND ? 32'(pend) : {int_req, 28'd0, vec};
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: randomized scoreboard bench for int_ctrl against a cycle-level reference model
module tb_int_ctrl;
  logic clk = 0, reset = 0, we = 0;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [5:0] src = 0, hwint;
  logic int_req;
  int checks = 0, errors = 0;

  localparam logic [5:0] SYNC = 6'b000100;

  int_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
    .src(src), .hwint(hwint), .int_req(int_req)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] a; logic [31:0] rd; logic [5:0] hw; logic rq; } exp_t;
  exp_t sb[$];

  logic [5:0] m_mask, m_mode, m_pend;
  logic [5:0] h[4];

  function automatic void model_reset();
    m_mask = 6'h07; m_mode = 0; m_pend = 0;
    for (int k = 0; k < 4; k++) h[k] = 0;
  endfunction

  // value src_q of line i held 'age' edges ago, from the raw sample history
  function automatic logic sq(int i, int age);
    return SYNC[i] ? h[age + 1][i] : h[age][i];
  endfunction

  function automatic exp_t expect_now(logic [1:0] a);
    exp_t e;
    logic [5:0] hw;
    logic [2:0] idx;
    hw = m_pend & m_mask;
    idx = 0;
    for (int i = 5; i >= 0; i--) if (hw[i]) idx = 3'(i);
    e.a = a; e.hw = hw; e.rq = hw != 0;
    case (a)
      2'd0: e.rd = {26'd0, m_mask};
      2'd1: e.rd = {26'd0, m_mode};
      2'd2: e.rd = {26'd0, m_pend};
      default: e.rd = {e.rq, 28'd0, idx};
    endcase
    return e;
  endfunction

  function automatic void model_edge(logic [5:0] s, logic w, logic [1:0] a, logic [31:0] d);
    logic [5:0] clr, nmode, np;
    clr = (w && a == 2) ? d[5:0] : 6'd0;
    nmode = (w && a == 1) ? d[5:0] : m_mode;
    for (int i = 0; i < 6; i++)
      np[i] = nmode[i] ? sq(i, 0) : ((sq(i, 0) & ~sq(i, 1)) | (m_pend[i] & ~clr[i]));
    m_pend = np;
    m_mode = nmode;
    if (w && a == 0) m_mask = d[5:0];
    for (int k = 3; k > 0; k--) h[k] = h[k - 1];
    h[0] = s;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // called at a falling edge; leaves the caller at the next falling edge
  task automatic cyc(logic [5:0] s, logic w, logic [1:0] a, logic [31:0] d);
    src = s; we = w; addr = a; wdata = d;
    sb.push_back(expect_now(a));
    @(posedge clk);
    model_edge(s, w, a, d);
    @(negedge clk);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("rdata[addr=%0d]", e.a), rdata, e.rd);
      check("hwint", 32'(hwint), 32'(e.hw));
      check("int_req", 32'(int_req), 32'(e.rq));
    end
  end

  initial begin
    logic [5:0] s;
    model_reset();
    src = 6'h3F;
    repeat (3) @(negedge clk);
    #2;
    check("reset hwint", 32'(hwint), 32'd0);
    check("reset int_req", 32'(int_req), 32'd0);
    src = 0;
    @(negedge clk);
    reset = 1;
    for (int a = 0; a < 4; a++) cyc(0, 0, 2'(a), 0);
    cyc(6'h01, 0, 2, 0); cyc(0, 0, 2, 0); cyc(0, 0, 2, 0);
    cyc(0, 1, 2, 32'h1); cyc(0, 0, 3, 0); cyc(0, 0, 2, 0);
    cyc(6'h02, 0, 2, 0); cyc(6'h02, 1, 2, 32'h2); cyc(6'h02, 0, 2, 0);
    cyc(0, 1, 2, 32'h2); cyc(0, 0, 2, 0);
    cyc(0, 1, 1, 32'h2); cyc(6'h02, 0, 2, 0); cyc(6'h02, 0, 2, 0);
    cyc(6'h02, 1, 2, 32'h2); cyc(6'h02, 0, 2, 0);
    cyc(0, 0, 2, 0); cyc(0, 0, 2, 0); cyc(0, 0, 2, 0);
    cyc(0, 1, 1, 0); cyc(0, 0, 1, 0);
    cyc(6'h06, 0, 2, 0); cyc(0, 0, 2, 0); cyc(0, 0, 3, 0); cyc(0, 0, 3, 0);
    cyc(0, 1, 0, 32'hFFFF_FFC4); cyc(0, 0, 3, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 2, 32'h3F); cyc(0, 1, 0, 32'h7);
    cyc(6'h05, 0, 2, 0); cyc(0, 0, 2, 0); cyc(0, 0, 2, 0); cyc(0, 0, 2, 0);
    cyc(6'h3F, 0, 1, 0); cyc(6'h3F, 1, 1, 32'h3F); cyc(6'h3F, 0, 2, 0); cyc(6'h3F, 1, 1, 0);
    cyc(6'h3F, 0, 2, 0); cyc(6'h3F, 0, 2, 0); cyc(6'h3F, 1, 0, 32'h3F); cyc(6'h3F, 0, 3, 0);
    #3 reset = 0;
    #1;
    check("async reset hwint", 32'(hwint), 32'd0);
    check("async reset int_req", 32'(int_req), 32'd0);
    src = 0; we = 0;
    @(negedge clk);
    reset = 1;
    model_reset();
    cyc(0, 0, 0, 0); cyc(0, 0, 2, 0);
    s = 0;
    for (int n = 0; n < 800; n++) begin
      logic w;
      if ($urandom_range(0, 3) == 0) s = 6'($urandom);
      w = $urandom_range(0, 4) == 0;
      cyc(s, w, 2'($urandom_range(0, 3)), $urandom);
    end
    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
